digit_scan_ctrl: RTL and testbench

//   Upstream scan controller for the 2-to-4 active-high decoder that drives a 4-digit display.

---
 rtl/digit_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit display fed through a 2-to-4 decoder.
// Blanks between positions and double-buffers the frame, committing only at frame boundaries.
module digit_scan_ctrl #(
    parameter int DIV   = 4096,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [1:0]  A,
    output logic        E,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [15:0]   active_q, active_n;
    logic [15:0]   shadow_q, shadow_n;
    logic          pending_q, pending_n;

    logic [1:0]    a_n;
    logic          e_n;
    logic [3:0]    digit_n;
    logic          fd_n;
    logic          commit;
    logic          accept;

    assign accept = din_valid && !pending_q;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        a_n       = A;
        e_n       = E;
        digit_n   = digit;
        fd_n      = 1'b0;
        commit    = 1'b0;
        active_n  = active_q;
        shadow_n  = shadow_q;
        pending_n = pending_q;

        case (state_q)
            ST_OFF: begin
                a_n     = 2'd0;
                e_n     = 1'b0;
                digit_n = 4'd0;
                cnt_n   = '0;
                if (en) begin
                    state_n = ST_BLANK;
                    commit  = 1'b1;
                end
            end
            ST_BLANK: begin
                e_n     = 1'b0;
                digit_n = 4'd0;
                if (cnt_q == BLANK_LAST) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                    e_n     = 1'b1;
                    digit_n = active_q[{A, 2'b00} +: 4];
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    a_n     = A + 2'd1;
                    e_n     = 1'b0;
                    digit_n = 4'd0;
                    // Leaving the last position is the frame boundary.
                    if (A == 2'd3) begin
                        fd_n   = 1'b1;
                        commit = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: begin
                state_n = ST_OFF;
            end
        endcase

        if (!en) begin
            state_n = ST_OFF;
            cnt_n   = '0;
            a_n     = 2'd0;
            e_n     = 1'b0;
            digit_n = 4'd0;
            fd_n    = 1'b0;
            commit  = 1'b0;
        end

        // Accept and a pending commit are mutually exclusive: accept needs pending clear.
        if (commit && pending_q) begin
            active_n  = shadow_q;
            pending_n = 1'b0;
        end
        if (accept) begin
            shadow_n  = din;
            pending_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            active_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            A          <= 2'd0;
            E          <= 1'b0;
            digit      <= 4'd0;
            frame_done <= 1'b0;
            din_ready  <= 1'b1;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            active_q   <= active_n;
            shadow_q   <= shadow_n;
            pending_q  <= pending_n;
            A          <= a_n;
            E          <= e_n;
            digit      <= digit_n;
            frame_done <= fd_n;
            din_ready  <= !pending_n;
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl (DIV=4, BLANK=2): reset/load vector table, then scoreboarded scan sequences.
module tb_digit_scan_ctrl;

    localparam int DIV_P   = 4;
    localparam int BLANK_P = 2;
    localparam int POS     = DIV_P + BLANK_P;
    localparam int FRAME   = 4 * POS;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [1:0]  A;
    logic        E;
    logic [3:0]  digit;
    logic        frame_done;
    logic [3:0]  dec_d;

    always #5 clk = ~clk;

    digit_scan_ctrl #(
        .DIV   (DIV_P),
        .BLANK (BLANK_P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .A          (A),
        .E          (E),
        .digit      (digit),
        .frame_done (frame_done)
    );

    // Attached 2-to-4 active-high decoder
    assign dec_d = E ? (4'b0001 << A) : 4'b0000;

    typedef struct {
        logic [1:0] a;
        logic       e;
        logic [3:0] digit;
        logic       fd;
        logic       rdy;
        string      tag;
    } exp_t;

    typedef struct {
        logic        r;
        logic        en;
        logic        v;
        logic [15:0] d;
        logic [1:0]  a;
        logic        e;
        logic [3:0]  dg;
        logic        fd;
        logic        rdy;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_err = 0;

    // Timing model: position/phase derived from edges since scan start
    bit          m_on    = 1'b0;
    int          m_j     = 0;
    logic [15:0] m_frame = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pend  = 1'b0;

    function automatic exp_t model_step(input logic r, input logic en_i, input logic v,
                                        input logic [15:0] d, input string tag);
        exp_t x;
        int   p;
        int   ph;
        x.tag = tag;
        x.a = 2'd0; x.e = 1'b0; x.digit = 4'd0; x.fd = 1'b0;
        if (r) begin
            m_on = 1'b0; m_j = 0; m_frame = '0; m_shadow = '0; m_pend = 1'b0;
        end else if (!en_i) begin
            m_on = 1'b0;
            if (v && !m_pend) begin
                m_shadow = d; m_pend = 1'b1;
            end
        end else begin
            if (!m_on) begin
                m_on = 1'b1; m_j = 0;
            end else begin
                m_j++;
            end
            if (m_pend) begin
                if (m_j % FRAME == 0) begin
                    m_frame = m_shadow; m_pend = 1'b0;
                end
            end else if (v) begin
                m_shadow = d; m_pend = 1'b1;
            end
            p  = (m_j / POS) % 4;
            ph = m_j % POS;
            x.a     = 2'(p);
            x.e     = (ph >= BLANK_P);
            x.digit = x.e ? m_frame[4*p +: 4] : 4'd0;
            x.fd    = (m_j % FRAME == 0) && (m_j > 0);
        end
        x.rdy = !m_pend;
        return x;
    endfunction

    task automatic check_outputs();
        exp_t       x;
        logic [3:0] exp_dec;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: got empty queue, want an expected entry");
            return;
        end
        x = sb.pop_front();
        n_vec++;
        if ({A, E, digit, frame_done, din_ready} !== {x.a, x.e, x.digit, x.fd, x.rdy}) begin
            n_err++;
            $display("FAIL %s @%0t: got A=%0d E=%0d digit=%h fd=%0d rdy=%0d, want A=%0d E=%0d digit=%h fd=%0d rdy=%0d",
                     x.tag, $time, A, E, digit, frame_done, din_ready, x.a, x.e, x.digit, x.fd, x.rdy);
        end
        exp_dec = x.e ? (4'b0001 << x.a) : 4'b0000;
        n_vec++;
        if (dec_d !== exp_dec) begin
            n_err++;
            $display("FAIL decoder_%s @%0t: got D=%b, want D=%b", x.tag, $time, dec_d, exp_dec);
        end
    endtask

    task automatic cyc(input logic r, input logic en_i, input logic v,
                       input logic [15:0] d, input string tag);
        rst = r; en = en_i; din_valid = v; din = d;
        sb.push_back(model_step(r, en_i, v, d, tag));
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        exp_t x;
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0;

        //          r     en    v     din       A     E     dg    fd    rdy
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h4321, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0};

        for (int i = 0; i < 6; i++) begin
            rst = tbl[i].r; en = tbl[i].en; din_valid = tbl[i].v; din = tbl[i].d;
            x = model_step(tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].d, "tbl");
            x.a = tbl[i].a; x.e = tbl[i].e; x.digit = tbl[i].dg;
            x.fd = tbl[i].fd; x.rdy = tbl[i].rdy;
            x.tag = $sformatf("tbl%0d", i);
            sb.push_back(x);
            @(posedge clk);
            #1;
            check_outputs();
        end

        // Two frames of 4321, with 8765 loaded mid-frame and a second load ignored while pending
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 8)       cyc(1'b0, 1'b1, 1'b1, 16'h8765, "load");
            else if (k == 10) cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, "load_ignored");
            else              cyc(1'b0, 1'b1, 1'b0, 16'h0000, "scan");
        end

        // Drop en while showing position 2
        for (int k = 0; k < 15; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0000, "scan_a2");
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, "en_off");
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, "off_hold");

        // Restart; a load coincident with the start-of-frame commit waits one frame
        cyc(1'b0, 1'b1, 1'b1, 16'h1234, "restart");
        for (int k = 1; k < FRAME + 8; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0000, "rescan");

        // Reset mid-frame with a pending load
        cyc(1'b0, 1'b1, 1'b1, 16'hABCD, "load_pend");
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, "pend_hold");
        cyc(1'b1, 1'b1, 1'b0, 16'h0000, "rst_mid");
        for (int k = 0; k < FRAME + 2; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0000, "zero_frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
